// File: rtl/os_receiver.sv
// os_receiver: receive-side ordered-set classifier. Consumes the per-lane
// symbol stream from the RX gearbox, recognises SKP, EIOS and logical IDLE
// beats, assembles 16-symbol TS1/TS2 sets on every lane, and reports the
// decoded fields plus consecutive-identical-TS and IDLE-run counters.
module os_receiver #(
  parameter int MAX_NUM_LANES = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_WIDTH    = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [DATA_WIDTH*MAX_NUM_LANES-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH*MAX_NUM_LANES-1:0] s_axis_tkeep,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  input  logic [USER_WIDTH*MAX_NUM_LANES-1:0] s_axis_tuser,
  output logic                                s_axis_tready,
  input  logic [MAX_NUM_LANES-1:0]            active_lanes_i,
  input  logic                                clr_cnt_i,
  output logic                                os_valid_o,
  output logic [2:0]                          os_type_o,
  output logic [127:0]                        ordered_set_o,
  output logic [8*MAX_NUM_LANES-1:0]          lane_num_o,
  output logic                                lane_mismatch_o,
  output logic [7:0]                          consec_cnt_o,
  output logic [7:0]                          idle_cnt_o,
  output logic                                error_o
);

  localparam int SYMS     = DATA_WIDTH / 8;
  localparam int TS_SYMS  = 16;
  localparam int TS_BITS  = TS_SYMS * 8;
  localparam int TS_BEATS = TS_SYMS / SYMS;
  localparam int CW       = $clog2(TS_BEATS);
  localparam int BUS_DW   = DATA_WIDTH * MAX_NUM_LANES;
  localparam int BUS_UW   = USER_WIDTH * MAX_NUM_LANES;

  localparam logic [CW-1:0]      LAST_BEAT = CW'(TS_BEATS - 1);
  // Lane-to-lane comparison ignores symbol 2 (the lane number).
  localparam logic [TS_BITS-1:0] SYM2_KEEP = ~(TS_BITS'(8'hFF) << 16);

  typedef enum logic [1:0] {ST_HUNT, ST_COLLECT, ST_CHECK} state_e;
  typedef enum logic [2:0] {
    OS_NONE = 3'd0, OS_TS1 = 3'd1, OS_TS2 = 3'd2,
    OS_SKP  = 3'd3, OS_EIOS = 3'd4, OS_IDLE = 3'd5
  } os_type_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d, store_idx;
  os_type_e        prev_type_q, os_type_d, ts_type;

  logic                 skid_full_q, skid_full_d, skid_load;
  logic [BUS_DW-1:0]    skid_data_q;
  logic [BUS_UW-1:0]    skid_user_q;
  logic                 skid_last_q;

  logic [TS_BITS-1:0]   ts_buf [MAX_NUM_LANES];

  logic                 in_check, cur_vld, cur_last, cur_com, cur_skp, cur_eios, cur_zero;
  logic [BUS_DW-1:0]    cur_data;
  logic [BUS_UW-1:0]    cur_user;
  logic                 pat_ts1, pat_ts2, mismatch_d, ts_same, ovf_err;
  logic                 ev_skp, ev_eios, ev_idle, ev_err, ev_ts1, ev_ts2, store_beat;
  logic                 ts_ok, err_any;
  logic [8*MAX_NUM_LANES-1:0] lane_num_d;

  // Keep is architecturally ignored; folding it here documents that.
  logic unused_keep;
  assign unused_keep = ^s_axis_tkeep;

  // Ready is low only while reset is asserted.
  assign s_axis_tready = ~rst_i;

  // Select the beat to classify: skid contents have priority over the bus.
  always_comb begin
    in_check    = (state_q == ST_CHECK);
    cur_vld     = !in_check && (skid_full_q || s_axis_tvalid);
    cur_data    = skid_full_q ? skid_data_q : s_axis_tdata;
    cur_user    = skid_full_q ? skid_user_q : s_axis_tuser;
    cur_last    = skid_full_q ? skid_last_q : s_axis_tlast;
    skid_load   = s_axis_tvalid && (in_check ? !skid_full_q : skid_full_q);
    skid_full_d = in_check ? (skid_full_q || s_axis_tvalid) : (skid_full_q && s_axis_tvalid);
    ovf_err     = s_axis_tvalid && in_check && skid_full_q;
  end

  // Decode lane-0 symbol patterns of the selected beat and of the TS buffers.
  always_comb begin
    cur_com  = (cur_data[7:0] == 8'hBC) && cur_user[0];
    cur_skp  = 1'b1;
    cur_eios = 1'b1;
    for (int k = 1; k < SYMS; k++) begin
      cur_skp  = cur_skp  && (cur_data[8*k +: 8] == 8'h1C) && cur_user[k];
      cur_eios = cur_eios && (cur_data[8*k +: 8] == 8'h7C) && cur_user[k];
    end
    cur_zero = (cur_data == '0) && (cur_user == '0);
    pat_ts1  = 1'b1;
    pat_ts2  = 1'b1;
    for (int n = 6; n < TS_SYMS; n++) begin
      pat_ts1 = pat_ts1 && (ts_buf[0][8*n +: 8] == 8'h4A);
      pat_ts2 = pat_ts2 && (ts_buf[0][8*n +: 8] == 8'h45);
    end
  end

  // Lane consistency and lane numbers of the assembled TS.
  always_comb begin
    mismatch_d = 1'b0;
    lane_num_d = '0;
    for (int i = 0; i < MAX_NUM_LANES; i++) begin
      lane_num_d[8*i +: 8] = ts_buf[i][23:16];
      if (i > 0 && active_lanes_i[i] &&
          ((ts_buf[i] & SYM2_KEEP) != (ts_buf[0] & SYM2_KEEP)))
        mismatch_d = 1'b1;
    end
  end

  // Next-state and event decode.
  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    store_idx  = '0;
    store_beat = 1'b0;
    ev_skp     = 1'b0;
    ev_eios    = 1'b0;
    ev_idle    = 1'b0;
    ev_err     = 1'b0;
    ev_ts1     = 1'b0;
    ev_ts2     = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (cur_vld) begin
          if (cur_com) begin
            if (cur_skp && cur_last) begin
              ev_skp = 1'b1;
            end else if (cur_eios && cur_last) begin
              ev_eios = 1'b1;
            end else if (!cur_last) begin
              store_beat = 1'b1;
              beat_cnt_d = CW'(1);
              state_d    = ST_COLLECT;
            end else begin
              ev_err = 1'b1;
            end
          end else if (cur_zero) begin
            ev_idle = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (cur_vld) begin
          store_idx = beat_cnt_q;
          if (cur_com) begin
            ev_err  = 1'b1;
            state_d = ST_HUNT;
          end else if (beat_cnt_q == LAST_BEAT) begin
            store_beat = 1'b1;
            if (cur_last) begin
              state_d = ST_CHECK;
            end else begin
              ev_err  = 1'b1;
              state_d = ST_HUNT;
            end
          end else if (cur_last) begin
            ev_err  = 1'b1;
            state_d = ST_HUNT;
          end else begin
            store_beat = 1'b1;
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      ST_CHECK: begin
        state_d = ST_HUNT;
        if (pat_ts1)      ev_ts1 = 1'b1;
        else if (pat_ts2) ev_ts2 = 1'b1;
        else              ev_err = 1'b1;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Result encoding shared by the output registers.
  always_comb begin
    ts_ok   = ev_ts1 || ev_ts2;
    err_any = ev_err || ovf_err;
    ts_type = ev_ts1 ? OS_TS1 : OS_TS2;
    ts_same = (ts_type == prev_type_q) && (ts_buf[0] == ordered_set_o);
    if (ts_ok)        os_type_d = ts_type;
    else if (ev_skp)  os_type_d = OS_SKP;
    else if (ev_eios) os_type_d = OS_EIOS;
    else if (ev_idle) os_type_d = OS_IDLE;
    else              os_type_d = OS_NONE;
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_HUNT;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // TS assembly buffers and skid payload.
  // NOTE: these are datapath storage qualified by state/skid_full, so they are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (store_beat) begin
      for (int i = 0; i < MAX_NUM_LANES; i++)
        ts_buf[i][DATA_WIDTH*store_idx +: DATA_WIDTH] <= cur_data[DATA_WIDTH*i +: DATA_WIDTH];
    end
    if (skid_load) begin
      skid_data_q <= s_axis_tdata;
      skid_user_q <= s_axis_tuser;
      skid_last_q <= s_axis_tlast;
    end
  end

  // Output pulses, decoded fields and run counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_full_q     <= 1'b0;
      os_valid_o      <= 1'b0;
      os_type_o       <= OS_NONE;
      error_o         <= 1'b0;
      ordered_set_o   <= '0;
      lane_num_o      <= '0;
      lane_mismatch_o <= 1'b0;
      consec_cnt_o    <= '0;
      idle_cnt_o      <= '0;
      prev_type_q     <= OS_NONE;
    end else begin
      skid_full_q <= skid_full_d;
      os_valid_o  <= ts_ok || ev_skp || ev_eios || ev_idle;
      os_type_o   <= os_type_d;
      error_o     <= err_any;
      if (ts_ok) begin
        ordered_set_o   <= ts_buf[0];
        lane_num_o      <= lane_num_d;
        lane_mismatch_o <= mismatch_d;
        prev_type_q     <= ts_type;
      end
      if (clr_cnt_i || err_any || ev_eios || ev_idle)
        consec_cnt_o <= '0;
      else if (ts_ok)
        consec_cnt_o <= !ts_same ? 8'd1 :
                        (consec_cnt_o == 8'hFF) ? 8'hFF : consec_cnt_o + 8'd1;
      if (clr_cnt_i || err_any || (cur_vld && cur_com))
        idle_cnt_o <= '0;
      else if (ev_idle && idle_cnt_o != 8'hFF)
        idle_cnt_o <= idle_cnt_o + 8'd1;
    end
  end

endmodule
